// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared constants for the sequenced 8x8 multiplier
package mul_seq_pkg;

  // Controller state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Step counter covers the four nibble partial products
  localparam int unsigned STEP_W    = 2;
  localparam logic [STEP_W-1:0] STEP_LAST = 2'd3;

  // Left shift applied to each partial product before accumulation
  localparam logic [3:0] SHIFT_S0 = 4'd0;
  localparam logic [3:0] SHIFT_S1 = 4'd4;
  localparam logic [3:0] SHIFT_S2 = 4'd4;
  localparam logic [3:0] SHIFT_S3 = 4'd8;

  // Nibble selects, one bit per step (bit n = step n): 1 picks the high nibble
  localparam logic [3:0] SEL_A_HI = 4'b1010;
  localparam logic [3:0] SEL_B_HI = 4'b1100;

  // Shift amount for a given step
  function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = SHIFT_S0;
      2'd1:    sh = SHIFT_S1;
      2'd2:    sh = SHIFT_S2;
      default: sh = SHIFT_S3;
    endcase
    return sh;
  endfunction

  // Pick the low or high nibble of a byte operand
  function automatic logic [3:0] pick_nibble(input logic [7:0] byte_v, input logic hi);
    return hi ? byte_v[7:4] : byte_v[3:0];
  endfunction

endpackage

// File: rtl/am_seq_mul8_am_design.sv
// rtl/am_seq_mul8_am_design.sv - 4x4 unsigned combinational array multiplier
module AM_design
  import mul_seq_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  logic [7:0] sum;
  logic [7:0] row;
  logic       carry;
  logic       nxt;

  // Each row is a_i gated by one bit of b_i, rippled into the running sum
  always_comb begin
    sum   = '0;
    row   = '0;
    carry = 1'b0;
    nxt   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      row   = {4'b0000, a_i & {4{b_i[i]}}} << i;
      carry = 1'b0;
      for (int j = 0; j < 8; j++) begin
        nxt    = sum[j] ^ row[j] ^ carry;
        carry  = (sum[j] & row[j]) | (carry & (sum[j] ^ row[j]));
        sum[j] = nxt;
      end
    end
    p_o = sum;
  end

endmodule

// File: rtl/am_seq_mul8.sv
// rtl/am_seq_mul8.sv - sequenced 8x8 multiplier sharing one 4x4 array core
module am_seq_mul8
  import mul_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
);

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [7:0]        a_q, a_d;
  logic [7:0]        b_q, b_d;
  logic [15:0]       acc_q, acc_d;

  logic [3:0]        core_a;
  logic [3:0]        core_b;
  logic [7:0]        core_p;
  logic [15:0]       core_term;

  // Route the nibble pair for the current step into the shared core
  always_comb begin
    core_a    = pick_nibble(a_q, SEL_A_HI[step_q]);
    core_b    = pick_nibble(b_q, SEL_B_HI[step_q]);
    core_term = {8'h00, core_p} << step_shift(step_q);
  end

  AM_design u_core (
    .a_i (core_a),
    .b_i (core_b),
    .p_o (core_p)
  );

  // Next-state: accept in IDLE, accumulate four steps, hold result until taken
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          step_d  = '0;
          state_d = ST_MUL;
        end
      end
      ST_MUL: begin
        acc_d  = acc_q + core_term;
        step_d = step_q + 2'd1;
        if (step_q == STEP_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight product
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
    end
  end

  // Handshake outputs decode state only; p is the accumulator itself
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    p         = acc_q;
  end

endmodule

// File: tb/tb_am_seq_mul8.sv
// tb/tb_am_seq_mul8.sv - directed self-checking bench for am_seq_mul8
module tb_am_seq_mul8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int n_cmp;
  int n_bad;

  am_seq_mul8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one operand pair, wait for the result, take it; caller sits on a negedge
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        output logic [15:0] prod, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    prod = p;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (p !== 16'h0000) begin n_bad++; $display("FAIL reset_p got=%h want=0000", p); end
  endtask

  task automatic test_basic();
    int lat;
    int busy_low;
    in_valid = 1'b1;
    a = 8'h12;
    b = 8'h34;
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_after_accept got=%b want=0", in_ready); end
    lat = 0;
    busy_low = 0;
    while (!out_valid && lat < 20) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      lat++;
    end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL basic_latency got=%0d want=4", lat); end
    n_cmp++; if (busy_low !== 0) begin n_bad++; $display("FAIL basic_busy_low_cycles got=%0d want=0", busy_low); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy_done got=%b want=1", busy); end
    n_cmp++; if (p !== 16'h03A8) begin n_bad++; $display("FAIL basic_p got=%h want=03a8", p); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_out_valid_after got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready_after got=%b want=1", in_ready); end
    n_cmp++; if (p !== 16'h03A8) begin n_bad++; $display("FAIL basic_p_hold got=%h want=03a8", p); end
  endtask

  task automatic test_max();
    logic [15:0] prod;
    int lat;
    run_op(8'hFF, 8'hFF, prod, lat);
    n_cmp++; if (prod !== 16'hFE01) begin n_bad++; $display("FAIL max_p got=%h want=fe01", prod); end
    n_cmp++; if (lat !== 4) begin n_bad++; $display("FAIL max_latency got=%0d want=4", lat); end
  endtask

  task automatic test_back_to_back();
    int lows;
    int w;
    logic seen1;
    logic [15:0] p1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = 8'h00;
    b = 8'hFF;
    @(negedge clk);
    a = 8'hA5;
    b = 8'h5A;
    lows = 0;
    seen1 = 1'b0;
    p1 = 16'hFFFF;
    while (!in_ready && lows < 20) begin
      if (out_valid) begin
        seen1 = 1'b1;
        p1 = p;
      end
      @(negedge clk);
      lows++;
    end
    n_cmp++; if (lows !== 5) begin n_bad++; $display("FAIL b2b_in_ready_low got=%0d want=5", lows); end
    n_cmp++; if (seen1 !== 1'b1) begin n_bad++; $display("FAIL b2b_first_valid got=%b want=1", seen1); end
    n_cmp++; if (p1 !== 16'h0000) begin n_bad++; $display("FAIL b2b_first_p got=%h want=0000", p1); end
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    n_cmp++; if (w !== 4) begin n_bad++; $display("FAIL b2b_second_latency got=%0d want=4", w); end
    n_cmp++; if (p !== 16'h3A02) begin n_bad++; $display("FAIL b2b_second_p got=%h want=3a02", p); end
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_after got=%b want=1", in_ready); end
  endtask

  task automatic test_backpressure();
    int w;
    int bad_hold;
    in_valid = 1'b1;
    a = 8'h0C;
    b = 8'h0D;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    bad_hold = 0;
    for (int k = 0; k < 3; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      a = 8'hEE;
      b = 8'hDD;
      @(negedge clk);
      if (out_valid !== 1'b1 || p !== 16'h009C || in_ready !== 1'b0) bad_hold++;
    end
    in_valid = 1'b0;
    n_cmp++; if (bad_hold !== 0) begin n_bad++; $display("FAIL bp_hold_cycles_bad got=%0d want=0 (p=%h)", bad_hold, p); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_stays_idle got=%b want=0", busy); end
    n_cmp++; if (p !== 16'h009C) begin n_bad++; $display("FAIL bp_p_after got=%h want=009c", p); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] prod;
    int lat;
    int pulses;
    in_valid = 1'b1;
    a = 8'h77;
    b = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got=%b want=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    n_cmp++; if (p !== 16'h0000) begin n_bad++; $display("FAIL rstmid_p got=%h want=0000", p); end
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rstmid_stray_valid got=%0d want=0", pulses); end
    run_op(8'h0F, 8'h10, prod, lat);
    n_cmp++; if (prod !== 16'h00F0) begin n_bad++; $display("FAIL rstmid_next_p got=%h want=00f0", prod); end
  endtask

  task automatic test_operand_change();
    int w;
    in_valid = 1'b1;
    a = 8'h80;
    b = 8'h02;
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 20) begin
      a = 8'($urandom);
      b = 8'($urandom);
      @(negedge clk);
      w++;
    end
    n_cmp++; if (p !== 16'h0100) begin n_bad++; $display("FAIL opchg_p got=%h want=0100", p); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_operand_change();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
